// File: rtl/cpu_pkg.sv
// Shared encodings for the five-stage CPU: memory access sizes and MEM-stage FSM states.
package cpu_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    MS_IDLE   = 2'd0,
    MS_ACCESS = 2'd1,
    MS_DONE   = 2'd2
  } mem_state_e;

endpackage

// File: rtl/load_align.sv
// Extracts the addressed byte/half/word from a memory read word and extends it to 32 bits.
module load_align
  import cpu_pkg::*;
(
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_signed,
  output logic [31:0] data_out
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    case (offset)
      2'd0:    byte_val = mem_rdata[7:0];
      2'd1:    byte_val = mem_rdata[15:8];
      2'd2:    byte_val = mem_rdata[23:16];
      default: byte_val = mem_rdata[31:24];
    endcase
    half_val = offset[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    // Size 11 falls through to a full-word load.
    case (size)
      SIZE_BYTE: data_out = {{24{is_signed & byte_val[7]}}, byte_val};
      SIZE_HALF: data_out = {{16{is_signed & half_val[15]}}, half_val};
      default:   data_out = mem_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues loads/stores to a variable-latency data memory, stalls the
// upstream stages while an access is outstanding, and flags misalignment and timeouts.
module mem_access_stage
  import cpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        valid,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [1:0]  memSize,
  input  logic        memSigned,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [3:0]  memByteEn,
  output logic [31:0] memWData,
  input  logic [31:0] memRData,
  input  logic        memReady,
  output logic [31:0] readData,
  output logic        stall,
  output logic        misaligned,
  output logic        busError
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  mem_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [3:0]       byte_en_q, byte_en_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             misaligned_q, misaligned_d;
  logic             bus_error_q, bus_error_d;
  logic [1:0]       offset_q, offset_d;
  logic [1:0]       size_q, size_d;
  logic             signed_q, signed_d;

  logic             is_access;
  logic             is_misaligned;
  logic [3:0]       lane_en;
  logic [31:0]      lane_wdata;
  logic [31:0]      load_data;

  assign is_access = valid && (memRead || memWrite);

  always_comb begin
    case (memSize)
      SIZE_BYTE: is_misaligned = 1'b0;
      SIZE_HALF: is_misaligned = address[0];
      default:   is_misaligned = |address[1:0];
    endcase
  end

  // Store lane steering from the live EX/MEM fields; latched on entry to ACCESS.
  always_comb begin
    case (memSize)
      SIZE_BYTE: begin
        lane_en    = 4'b0001 << address[1:0];
        lane_wdata = {4{writeData[7:0]}};
      end
      SIZE_HALF: begin
        lane_en    = address[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{writeData[15:0]}};
      end
      default: begin
        lane_en    = 4'b1111;
        lane_wdata = writeData;
      end
    endcase
  end

  load_align u_load_align (
    .mem_rdata (memRData),
    .offset    (offset_q),
    .size      (size_q),
    .is_signed (signed_q),
    .data_out  (load_data)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    byte_en_d    = byte_en_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    misaligned_d = 1'b0;
    bus_error_d  = 1'b0;
    offset_d     = offset_q;
    size_d       = size_q;
    signed_d     = signed_q;
    case (state_q)
      MS_IDLE: begin
        req_d = 1'b0;
        we_d  = 1'b0;
        if (is_access) begin
          if (is_misaligned) begin
            misaligned_d = 1'b1;
          end else begin
            state_d   = MS_ACCESS;
            cnt_d     = '0;
            req_d     = 1'b1;
            we_d      = !memRead;
            addr_d    = {address[31:2], 2'b00};
            byte_en_d = lane_en;
            wdata_d   = lane_wdata;
            offset_d  = address[1:0];
            size_d    = memSize;
            signed_d  = memSigned;
          end
        end
      end
      MS_ACCESS: begin
        // memReady takes precedence over a timeout landing in the same cycle.
        if (memReady) begin
          state_d = MS_DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          if (!we_q) begin
            rdata_d = load_data;
          end
        end else if (cnt_q == CNT_MAX) begin
          state_d     = MS_DONE;
          req_d       = 1'b0;
          we_d        = 1'b0;
          bus_error_d = 1'b1;
          rdata_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = MS_IDLE;
        req_d   = 1'b0;
        we_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= MS_IDLE;
      cnt_q        <= '0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      byte_en_q    <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      misaligned_q <= 1'b0;
      bus_error_q  <= 1'b0;
      offset_q     <= '0;
      size_q       <= SIZE_BYTE;
      signed_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      byte_en_q    <= byte_en_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      misaligned_q <= misaligned_d;
      bus_error_q  <= bus_error_d;
      offset_q     <= offset_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
    end
  end

  assign stall = !reset && ((state_q == MS_IDLE && is_access && !is_misaligned) ||
                            (state_q == MS_ACCESS));

  assign memReq     = req_q;
  assign memWe      = we_q;
  assign memAddr    = addr_q;
  assign memByteEn  = byte_en_q;
  assign memWData   = wdata_q;
  assign readData   = rdata_q;
  assign misaligned = misaligned_q;
  assign busError   = bus_error_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage, built with a 4-cycle timeout.
module tb_mem_access_stage;

  logic        clock;
  logic        reset;
  logic        valid;
  logic        memRead;
  logic        memWrite;
  logic [1:0]  memSize;
  logic        memSigned;
  logic [31:0] address;
  logic [31:0] writeData;
  logic        memReq;
  logic        memWe;
  logic [31:0] memAddr;
  logic [3:0]  memByteEn;
  logic [31:0] memWData;
  logic [31:0] memRData;
  logic        memReady;
  logic [31:0] readData;
  logic        stall;
  logic        misaligned;
  logic        busError;

  int checkCount = 0;
  int passCount  = 0;

  mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .valid      (valid),
    .memRead    (memRead),
    .memWrite   (memWrite),
    .memSize    (memSize),
    .memSigned  (memSigned),
    .address    (address),
    .writeData  (writeData),
    .memReq     (memReq),
    .memWe      (memWe),
    .memAddr    (memAddr),
    .memByteEn  (memByteEn),
    .memWData   (memWData),
    .memRData   (memRData),
    .memReady   (memReady),
    .readData   (readData),
    .stall      (stall),
    .misaligned (misaligned),
    .busError   (busError)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
  endtask

  task automatic applyStimulus(input logic v, input logic rd, input logic wr, input logic [1:0] sz,
                               input logic sgn, input logic [31:0] addr, input logic [31:0] wd);
    valid     = v;
    memRead   = rd;
    memWrite  = wr;
    memSize   = sz;
    memSigned = sgn;
    address   = addr;
    writeData = wd;
    #1;
  endtask

  task automatic stepCycle;
    @(posedge clock);
    #1;
  endtask

  // Starts in the issuing IDLE cycle; returns in the DONE cycle.
  task automatic runAccess(input int readyAfter, input logic [31:0] rdata, output int stallCycles,
                           output logic [3:0] firstByteEn, output logic [31:0] firstAddr,
                           output logic [31:0] firstWData, output logic firstWe);
    int accessCycles;
    stallCycles  = 0;
    accessCycles = 0;
    firstByteEn  = 4'h0;
    firstAddr    = 32'h0;
    firstWData   = 32'h0;
    firstWe      = 1'b0;
    if (stall) stallCycles++;
    stepCycle();
    firstByteEn = memByteEn;
    firstAddr   = memAddr;
    firstWData  = memWData;
    firstWe     = memWe;
    while (memReq && accessCycles < 40) begin
      if (stall) stallCycles++;
      memReady = (accessCycles == readyAfter);
      memRData = rdata;
      accessCycles++;
      @(posedge clock);
      #1;
    end
    memReady = 1'b0;
    memRData = 32'h5A5A_5A5A;
    checkOutput("accessBounded", 32'(accessCycles < 40), 32'd1);
  endtask

  task automatic retire;
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    stepCycle();
  endtask

  int         sc;
  logic [3:0] be;
  logic [31:0] ad;
  logic [31:0] wdo;
  logic        we;
  int          cyc;
  logic        seenBusErr;

  initial begin
    reset    = 1'b1;
    memReady = 1'b0;
    memRData = 32'h0;
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clock);
    #1;
    checkOutput("rstMemReq", 32'(memReq), 32'd0);
    checkOutput("rstMemWe", 32'(memWe), 32'd0);
    checkOutput("rstByteEn", 32'(memByteEn), 32'd0);
    checkOutput("rstAddr", memAddr, 32'h0);
    checkOutput("rstWData", memWData, 32'h0);
    checkOutput("rstReadData", readData, 32'h0);
    checkOutput("rstStall", 32'(stall), 32'd0);
    checkOutput("rstMisaligned", 32'(misaligned), 32'd0);
    checkOutput("rstBusError", 32'(busError), 32'd0);
    reset = 1'b0;
    stepCycle();

    $display("[TB] word load 0x100");
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    checkOutput("wordStallIssue", 32'(stall), 32'd1);
    runAccess(1, 32'hDEAD_BEEF, sc, be, ad, wdo, we);
    checkOutput("wordStallCycles", 32'(sc), 32'd3);
    checkOutput("wordByteEn", 32'(be), 32'hF);
    checkOutput("wordAddr", ad, 32'h100);
    checkOutput("wordWe", 32'(we), 32'd0);
    checkOutput("wordDoneStall", 32'(stall), 32'd0);
    checkOutput("wordDoneReq", 32'(memReq), 32'd0);
    checkOutput("wordReadData", readData, 32'hDEAD_BEEF);
    retire();

    $display("[TB] byte loads 0x103");
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0);
    runAccess(0, 32'h8000_0000, sc, be, ad, wdo, we);
    checkOutput("sbyteStallCycles", 32'(sc), 32'd2);
    checkOutput("sbyteByteEn", 32'(be), 32'h8);
    checkOutput("sbyteAddr", ad, 32'h100);
    checkOutput("sbyteReadData", readData, 32'hFFFF_FF80);
    retire();
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0);
    runAccess(0, 32'h8000_0000, sc, be, ad, wdo, we);
    checkOutput("ubyteReadData", readData, 32'h0000_0080);
    retire();

    $display("[TB] memReady ignored while idle");
    memReady = 1'b1;
    memRData = 32'h1111_2222;
    stepCycle();
    memReady = 1'b0;
    checkOutput("idleReadyIgnored", readData, 32'h0000_0080);
    checkOutput("idleReadyNoReq", 32'(memReq), 32'd0);

    $display("[TB] half store 0x202");
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 32'h202, 32'h0000_ABCD);
    runAccess(0, 32'h0, sc, be, ad, wdo, we);
    checkOutput("hstoreWe", 32'(we), 32'd1);
    checkOutput("hstoreByteEn", 32'(be), 32'hC);
    checkOutput("hstoreWData", wdo, 32'hABCD_ABCD);
    checkOutput("hstoreAddr", ad, 32'h200);
    checkOutput("hstoreStallCycles", 32'(sc), 32'd2);
    checkOutput("hstoreReadHeld", readData, 32'h0000_0080);
    retire();

    $display("[TB] byte store 0x101 and signed half load 0x202");
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h101, 32'h1234_5677);
    runAccess(0, 32'h0, sc, be, ad, wdo, we);
    checkOutput("bstoreByteEn", 32'(be), 32'h2);
    checkOutput("bstoreWData", wdo, 32'h7777_7777);
    retire();
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 32'h202, 32'h0);
    runAccess(2, 32'h8001_1234, sc, be, ad, wdo, we);
    checkOutput("shalfReadData", readData, 32'hFFFF_8001);
    checkOutput("shalfStallCycles", 32'(sc), 32'd4);
    retire();

    $display("[TB] misaligned word load 0x105");
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h105, 32'h0);
    checkOutput("misStall", 32'(stall), 32'd0);
    stepCycle();
    checkOutput("misPulse", 32'(misaligned), 32'd1);
    checkOutput("misNoReq", 32'(memReq), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    stepCycle();
    checkOutput("misPulseEnd", 32'(misaligned), 32'd0);
    checkOutput("misNoReqAfter", 32'(memReq), 32'd0);
    checkOutput("misReadHeld", readData, 32'hFFFF_8001);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 32'h201, 32'h0);
    stepCycle();
    checkOutput("misHalfPulse", 32'(misaligned), 32'd1);
    retire();

    $display("[TB] timeout with memReady held low");
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h300, 32'h0);
    seenBusErr = 1'b0;
    cyc = 0;
    while (!busError && cyc < 30) begin
      stepCycle();
      cyc++;
    end
    seenBusErr = busError;
    checkOutput("toBusError", 32'(seenBusErr), 32'd1);
    checkOutput("toCycles", 32'(cyc), 32'd6);
    checkOutput("toReadData", readData, 32'h0);
    checkOutput("toStall", 32'(stall), 32'd0);
    checkOutput("toReqDropped", 32'(memReq), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    stepCycle();
    checkOutput("toPulseEnd", 32'(busError), 32'd0);
    checkOutput("toIdleStall", 32'(stall), 32'd0);

    $display("[TB] memReady on the timeout cycle");
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h304, 32'h0);
    runAccess(4, 32'hCAFE_F00D, sc, be, ad, wdo, we);
    checkOutput("raceBusError", 32'(busError), 32'd0);
    checkOutput("raceReadData", readData, 32'hCAFE_F00D);
    checkOutput("raceStallCycles", 32'(sc), 32'd6);
    retire();

    $display("[TB] reset during ACCESS");
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
    stepCycle();
    checkOutput("rstMidReqHigh", 32'(memReq), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rstMidReq", 32'(memReq), 32'd0);
    checkOutput("rstMidStall", 32'(stall), 32'd0);
    checkOutput("rstMidReadData", readData, 32'h0);
    stepCycle();
    reset = 1'b0;
    #1;
    checkOutput("rstRelStall", 32'(stall), 32'd1);
    runAccess(1, 32'h1234_5678, sc, be, ad, wdo, we);
    checkOutput("rstRelAddr", ad, 32'h400);
    checkOutput("rstRelReadData", readData, 32'h1234_5678);
    checkOutput("rstRelStallCycles", 32'(sc), 32'd3);
    retire();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
